// File: rtl/tracker_packet_rx.sv
// UART (8N1) receiver for 9-byte body-tracking records: 0xA5, ID, XH, XL, YH, YL, ZH, ZL, CHK.
// Validated records are committed to the per-ID hand/head coordinate registers.
module tracker_packet_rx #(
    parameter int CLKS_PER_BIT = 564,
    parameter int TIMEOUT_CLKS = 65000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        uart_rx_in,
    output logic [11:0] hand_x_left_bottom,
    output logic [11:0] hand_y_left_bottom,
    output logic [13:0] hand_z_left_bottom,
    output logic [11:0] hand_x_left_top,
    output logic [11:0] hand_y_left_top,
    output logic [13:0] hand_z_left_top,
    output logic [11:0] hand_x_right_bottom,
    output logic [11:0] hand_y_right_bottom,
    output logic [13:0] hand_z_right_bottom,
    output logic [11:0] hand_x_right_top,
    output logic [11:0] hand_y_right_top,
    output logic [13:0] hand_z_right_top,
    output logic [11:0] head_x,
    output logic [11:0] head_y,
    output logic [13:0] head_z,
    output logic        update_out,
    output logic [2:0]  update_id_out,
    output logic [7:0]  err_count_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] TIMEOUT_LAST = IW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP
    } byte_state_t;

    typedef enum logic [3:0] {
        PKT_SYNC,
        PKT_ID,
        PKT_XH,
        PKT_XL,
        PKT_YH,
        PKT_YL,
        PKT_ZH,
        PKT_ZL,
        PKT_CHK
    } pkt_state_t;

    logic sync1, sync2, rx_sync, rx_prev;

    byte_state_t byte_state, byte_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0] bit_idx, bit_next;
    logic [7:0] shift, shift_next;
    logic byte_valid, valid_next;
    logic frame_err, ferr_next;

    pkt_state_t pkt_state, pkt_next;
    logic [7:0] id_reg, xor_acc;
    logic [3:0] xh_reg, yh_reg;
    logic [7:0] xl_reg, yl_reg;
    logic [5:0] zh_reg;
    logic [7:0] zl_reg;
    logic [IW-1:0] idle_cnt;
    logic commit, chk_err, timeout_hit;

    logic [11:0] x_reg [5];
    logic [11:0] y_reg [5];
    logic [13:0] z_reg [5];

    assign rx_sync = sync2;

    // Synchroniser idles high so a reset never looks like a start bit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx_in;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            byte_state <= BYTE_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_state <= byte_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

    always_comb begin
        byte_next  = byte_state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (byte_state)
            BYTE_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    byte_next = BYTE_START;
                    cnt_next  = HALF_BIT;
                end
            end
            BYTE_START: begin
                if (cnt == '0) begin
                    if (!rx_sync) begin
                        byte_next = BYTE_DATA;
                        cnt_next  = FULL_BIT;
                        bit_next  = '0;
                    end else begin
                        byte_next = BYTE_IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            BYTE_DATA: begin
                if (cnt == '0) begin
                    shift_next = {rx_sync, shift[7:1]};
                    cnt_next   = FULL_BIT;
                    if (bit_idx == 3'd7) begin
                        byte_next = BYTE_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            BYTE_STOP: begin
                if (cnt == '0) begin
                    byte_next = BYTE_IDLE;
                    if (rx_sync) begin
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: byte_next = BYTE_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pkt_state <= PKT_SYNC;
        end else begin
            pkt_state <= pkt_next;
        end
    end

    // Framing errors and timeouts abandon the packet; a byte cannot arrive in the same cycle as either.
    always_comb begin
        pkt_next    = pkt_state;
        commit      = 1'b0;
        chk_err     = 1'b0;
        timeout_hit = (pkt_state != PKT_SYNC) && !byte_valid && (idle_cnt >= TIMEOUT_LAST);
        if (frame_err || timeout_hit) begin
            pkt_next = PKT_SYNC;
        end else if (byte_valid) begin
            case (pkt_state)
                PKT_SYNC: if (shift == SYNC_BYTE) pkt_next = PKT_ID;
                PKT_ID:   pkt_next = PKT_XH;
                PKT_XH:   pkt_next = PKT_XL;
                PKT_XL:   pkt_next = PKT_YH;
                PKT_YH:   pkt_next = PKT_YL;
                PKT_YL:   pkt_next = PKT_ZH;
                PKT_ZH:   pkt_next = PKT_ZL;
                PKT_ZL:   pkt_next = PKT_CHK;
                PKT_CHK: begin
                    pkt_next = PKT_SYNC;
                    if (shift == xor_acc && id_reg <= 8'd4) begin
                        commit = 1'b1;
                    end else begin
                        chk_err = 1'b1;
                    end
                end
                default:  pkt_next = PKT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            id_reg   <= '0;
            xor_acc  <= '0;
            xh_reg   <= '0;
            xl_reg   <= '0;
            yh_reg   <= '0;
            yl_reg   <= '0;
            zh_reg   <= '0;
            zl_reg   <= '0;
            idle_cnt <= '0;
        end else begin
            if (byte_valid || pkt_state == PKT_SYNC) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TIMEOUT_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (byte_valid) begin
                case (pkt_state)
                    PKT_SYNC: if (shift == SYNC_BYTE) xor_acc <= '0;
                    PKT_ID:   begin id_reg <= shift;      xor_acc <= xor_acc ^ shift; end
                    PKT_XH:   begin xh_reg <= shift[3:0]; xor_acc <= xor_acc ^ shift; end
                    PKT_XL:   begin xl_reg <= shift;      xor_acc <= xor_acc ^ shift; end
                    PKT_YH:   begin yh_reg <= shift[3:0]; xor_acc <= xor_acc ^ shift; end
                    PKT_YL:   begin yl_reg <= shift;      xor_acc <= xor_acc ^ shift; end
                    PKT_ZH:   begin zh_reg <= shift[5:0]; xor_acc <= xor_acc ^ shift; end
                    PKT_ZL:   begin zl_reg <= shift;      xor_acc <= xor_acc ^ shift; end
                    default:  ;
                endcase
            end
        end
    end

    // The checksum byte itself is still in the shift register, so ZL comes from zl_reg.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 5; i++) begin
                x_reg[i] <= '0;
                y_reg[i] <= '0;
                z_reg[i] <= '0;
            end
            update_out    <= 1'b0;
            update_id_out <= '0;
            err_count_out <= '0;
        end else begin
            update_out <= commit;
            if (commit) begin
                update_id_out <= id_reg[2:0];
                for (int i = 0; i < 5; i++) begin
                    if (id_reg[2:0] == 3'(i)) begin
                        x_reg[i] <= {xh_reg, xl_reg};
                        y_reg[i] <= {yh_reg, yl_reg};
                        z_reg[i] <= {zh_reg, zl_reg};
                    end
                end
            end
            if ((frame_err || chk_err || timeout_hit) && err_count_out != 8'hFF) begin
                err_count_out <= err_count_out + 8'd1;
            end
        end
    end

    assign hand_x_left_bottom  = x_reg[0];
    assign hand_y_left_bottom  = y_reg[0];
    assign hand_z_left_bottom  = z_reg[0];
    assign hand_x_left_top     = x_reg[1];
    assign hand_y_left_top     = y_reg[1];
    assign hand_z_left_top     = z_reg[1];
    assign hand_x_right_bottom = x_reg[2];
    assign hand_y_right_bottom = y_reg[2];
    assign hand_z_right_bottom = z_reg[2];
    assign hand_x_right_top    = x_reg[3];
    assign hand_y_right_top    = y_reg[3];
    assign hand_z_right_top    = z_reg[3];
    assign head_x              = x_reg[4];
    assign head_y              = y_reg[4];
    assign head_z              = z_reg[4];

endmodule

// File: tb/tb_tracker_packet_rx.sv
// Scoreboard bench for tracker_packet_rx: directed UART records in, committed coordinates checked
// by a monitor against a shadow copy of the 15 registers.
module tb_tracker_packet_rx;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic uart_rx_in = 1'b1;

    logic [11:0] hand_x_left_bottom, hand_y_left_bottom, hand_x_left_top, hand_y_left_top;
    logic [11:0] hand_x_right_bottom, hand_y_right_bottom, hand_x_right_top, hand_y_right_top;
    logic [11:0] head_x, head_y;
    logic [13:0] hand_z_left_bottom, hand_z_left_top, hand_z_right_bottom, hand_z_right_top, head_z;
    logic        update_out;
    logic [2:0]  update_id_out;
    logic [7:0]  err_count_out;

    tracker_packet_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .uart_rx_in(uart_rx_in),
        .hand_x_left_bottom(hand_x_left_bottom),
        .hand_y_left_bottom(hand_y_left_bottom),
        .hand_z_left_bottom(hand_z_left_bottom),
        .hand_x_left_top(hand_x_left_top),
        .hand_y_left_top(hand_y_left_top),
        .hand_z_left_top(hand_z_left_top),
        .hand_x_right_bottom(hand_x_right_bottom),
        .hand_y_right_bottom(hand_y_right_bottom),
        .hand_z_right_bottom(hand_z_right_bottom),
        .hand_x_right_top(hand_x_right_top),
        .hand_y_right_top(hand_y_right_top),
        .hand_z_right_top(hand_z_right_top),
        .head_x(head_x),
        .head_y(head_y),
        .head_z(head_z),
        .update_out(update_out),
        .update_id_out(update_id_out),
        .err_count_out(err_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]  id;
        logic [11:0] x;
        logic [11:0] y;
        logic [13:0] z;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_rec;
    logic [11:0] mx [5];
    logic [11:0] my [5];
    logic [13:0] mz [5];
    logic [11:0] ox [5];
    logic [11:0] oy [5];
    logic [13:0] oz [5];
    int vectors = 0;
    int miscompares = 0;

    assign ox[0] = hand_x_left_bottom;  assign oy[0] = hand_y_left_bottom;  assign oz[0] = hand_z_left_bottom;
    assign ox[1] = hand_x_left_top;     assign oy[1] = hand_y_left_top;     assign oz[1] = hand_z_left_top;
    assign ox[2] = hand_x_right_bottom; assign oy[2] = hand_y_right_bottom; assign oz[2] = hand_z_right_bottom;
    assign ox[3] = hand_x_right_top;    assign oy[3] = hand_y_right_top;    assign oz[3] = hand_z_right_top;
    assign ox[4] = head_x;              assign oy[4] = head_y;              assign oz[4] = head_z;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_output(input string tag);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("%s x[%0d]", tag, i), 32'(ox[i]), 32'(mx[i]));
            check_val($sformatf("%s y[%0d]", tag, i), 32'(oy[i]), 32'(my[i]));
            check_val($sformatf("%s z[%0d]", tag, i), 32'(oz[i]), 32'(mz[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) begin
            mx[i] = '0;
            my[i] = '0;
            mz[i] = '0;
        end
    endtask

    // Every update pulse must match the oldest pending record; a second cycle of the same pulse
    // finds the queue empty and is reported.
    always @(negedge clk_in) begin
        if (rst_in && update_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_update: got update for id %0d, expected none", update_id_out);
            end else begin
                mon_rec = exp_q.pop_front();
                mx[mon_rec.id] = mon_rec.x;
                my[mon_rec.id] = mon_rec.y;
                mz[mon_rec.id] = mon_rec.z;
                check_val("update_id", 32'(update_id_out), 32'(mon_rec.id));
                check_output("commit");
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        uart_rx_in = stop_bit;
        repeat (CPB) @(negedge clk_in);
        uart_rx_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic apply_stimulus(input logic [7:0] id, input logic [7:0] xh, input logic [7:0] xl,
                                  input logic [7:0] yh, input logic [7:0] yl, input logic [7:0] zh,
                                  input logic [7:0] zl, input logic force_chk, input logic [7:0] chk_forced);
        logic [7:0] chk;
        chk = force_chk ? chk_forced : (id ^ xh ^ xl ^ yh ^ yl ^ zh ^ zl);
        send_byte(8'hA5, 1'b1);
        send_byte(id, 1'b1);
        send_byte(xh, 1'b1);
        send_byte(xl, 1'b1);
        send_byte(yh, 1'b1);
        send_byte(yl, 1'b1);
        send_byte(zh, 1'b1);
        send_byte(zl, 1'b1);
        send_byte(chk, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_in);
        check_val({tag, " pending_updates"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] yl_byte;
        clear_model();
        repeat (4) @(negedge clk_in);
        check_output("reset");
        check_val("reset update_out", 32'(update_out), 32'd0);
        check_val("reset update_id", 32'(update_id_out), 32'd0);
        check_val("reset err", 32'(err_count_out), 32'd0);
        rst_in = 1'b1;
        repeat (20) @(negedge clk_in);

        $display("[TB] valid ID 0 record");
        exp_q.push_back('{id: 3'd0, x: 12'h123, y: 12'h245, z: 14'h1388});
        apply_stimulus(8'h00, 8'h01, 8'h23, 8'h02, 8'h45, 8'h13, 8'h88, 1'b0, 8'h00);
        wait_drain("t1");
        check_val("t1 err", 32'(err_count_out), 32'd0);

        $display("[TB] bad checksum");
        apply_stimulus(8'h00, 8'h01, 8'h23, 8'h02, 8'h45, 8'h13, 8'h88, 1'b1, 8'h00);
        repeat (20) @(negedge clk_in);
        check_val("t2 err", 32'(err_count_out), 32'd1);
        check_output("t2 hold");

        $display("[TB] leading junk then ID 4");
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        exp_q.push_back('{id: 3'd4, x: 12'h3FF, y: 12'h2FF, z: 14'h3FFF});
        apply_stimulus(8'h04, 8'h03, 8'hFF, 8'h02, 8'hFF, 8'h3F, 8'hFF, 1'b0, 8'h00);
        wait_drain("t3");
        check_val("t3 err", 32'(err_count_out), 32'd1);

        $display("[TB] framing error then ID 1 with mid-packet A5 and discarded high bits");
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (20) @(negedge clk_in);
        check_val("t4 frame err", 32'(err_count_out), 32'd2);
        exp_q.push_back('{id: 3'd1, x: 12'h2A5, y: 12'hB7C, z: 14'h3F5A});
        apply_stimulus(8'h01, 8'h12, 8'hA5, 8'h0B, 8'h7C, 8'hFF, 8'h5A, 1'b0, 8'h00);
        wait_drain("t4");
        check_val("t4 err", 32'(err_count_out), 32'd2);

        $display("[TB] timeout then ID 2");
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h33, 1'b1);
        repeat (300) @(negedge clk_in);
        check_val("t5 timeout err", 32'(err_count_out), 32'd3);
        exp_q.push_back('{id: 3'd2, x: 12'h456, y: 12'h789, z: 14'h0ABC});
        apply_stimulus(8'h02, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC, 1'b0, 8'h00);
        wait_drain("t5");
        check_val("t5 err", 32'(err_count_out), 32'd3);

        $display("[TB] ID 5 with good checksum is rejected");
        apply_stimulus(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 1'b0, 8'h00);
        repeat (20) @(negedge clk_in);
        check_val("t7 err", 32'(err_count_out), 32'd4);
        check_output("t7 hold");

        $display("[TB] reset in the middle of YL");
        yl_byte = 8'h55;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            uart_rx_in = yl_byte[i];
            repeat (CPB) @(negedge clk_in);
        end
        rst_in = 1'b0;
        #1;
        clear_model();
        check_output("t6 reset");
        check_val("t6 reset err", 32'(err_count_out), 32'd0);
        check_val("t6 reset update_out", 32'(update_out), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 3; i < 8; i++) begin
            uart_rx_in = yl_byte[i];
            repeat (CPB) @(negedge clk_in);
        end
        uart_rx_in = 1'b1;
        repeat (CPB + 2) @(negedge clk_in);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (300) @(negedge clk_in);
        check_output("t6 no commit");
        exp_q.push_back('{id: 3'd3, x: 12'h111, y: 12'h222, z: 14'h0333});
        apply_stimulus(8'h03, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 1'b0, 8'h00);
        wait_drain("t6");

        repeat (20) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
